// File: rtl/genie_wrr_merge_ctl.sv
// Weighted round-robin merge controller with packet lock.
// A grant holder keeps the output for up to weff(i) packets per turn, and
// stays locked to the current input from the first beat of a packet until
// its eop beat. Arbitration is combinational, so packets from different
// inputs follow each other with no idle cycles in between.
module genie_wrr_merge_ctl #(
  parameter int NI     = 2,
  parameter int NIBITS = $clog2(NI),
  parameter int WBITS  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NI-1:0]       i_valid,
  input  logic [NI-1:0]       i_eop,
  input  logic [NI*WBITS-1:0] i_weight,
  input  logic                i_ready,
  output logic [NI-1:0]       o_ready,
  output logic [NIBITS-1:0]   o_sel,
  output logic                o_valid,
  output logic                o_eop,
  output logic                o_pkt_active
);

  typedef enum logic [0:0] {
    S_ARB = 1'b0,
    S_PKT = 1'b1
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [NIBITS-1:0]  last_r;
  logic [NIBITS-1:0]  last_nxt_s;
  logic [WBITS-1:0]   credit_r;
  logic [WBITS-1:0]   credit_nxt_s;
  logic [NIBITS-1:0]  rr_s;
  logic [NIBITS-1:0]  cand_s;
  logic               rr_found_s;
  logic               accept_s;
  logic               new_grant_s;
  logic [WBITS-1:0]   weff_s;

  // Effective quota of input sel: a zero weight field still grants one packet.
  function automatic logic [WBITS-1:0] weff_f(
    input logic [NI*WBITS-1:0] w,
    input logic [NIBITS-1:0]   sel
  );
    logic [WBITS-1:0] field;
    field = {WBITS{1'b0}};
    for (int i = 0; i < NI; i++) begin
      field = (sel == NIBITS'(i)) ? w[i*WBITS +: WBITS] : field;
    end
    return (field == {WBITS{1'b0}}) ? WBITS'(1'b1) : field;
  endfunction

  // Round-robin candidate: first valid input after last, wrapping back to last.
  always_comb begin
    rr_s       = last_r;
    rr_found_s = 1'b0;
    cand_s     = last_r;
    for (int k = 1; k <= NI; k++) begin
      cand_s     = NIBITS'((int'(last_r) + k) % NI);
      rr_s       = (!rr_found_s && i_valid[cand_s]) ? cand_s : rr_s;
      rr_found_s = rr_found_s | i_valid[cand_s];
    end
  end

  // Grant select and datapath-facing outputs; the lock in S_PKT pins o_sel to last.
  always_comb begin
    o_sel = last_r;
    case (state_r)
      S_ARB:   o_sel = ((credit_r != {WBITS{1'b0}}) && i_valid[last_r]) ? last_r : rr_s;
      S_PKT:   o_sel = last_r;
      default: o_sel = last_r;
    endcase
    o_valid      = i_valid[o_sel];
    o_eop        = i_eop[o_sel];
    o_pkt_active = (state_r == S_PKT);
    o_ready      = {NI{1'b0}};
    for (int i = 0; i < NI; i++) begin
      o_ready[i] = i_ready & reset & (o_sel == NIBITS'(i));
    end
  end

  // Beat acceptance, turn accounting and packet-lock next state.
  always_comb begin
    accept_s     = o_valid & i_ready;
    new_grant_s  = (state_r == S_ARB) && accept_s &&
                   ((o_sel != last_r) || (credit_r == {WBITS{1'b0}}));
    weff_s       = weff_f(i_weight, o_sel);
    state_nxt_s  = state_r;
    last_nxt_s   = last_r;
    credit_nxt_s = credit_r;
    if (accept_s) begin
      last_nxt_s = o_sel;
      if (new_grant_s) begin
        // The quota is latched only here, so weight changes mid-turn are ignored.
        credit_nxt_s = o_eop ? (weff_s - WBITS'(1'b1)) : weff_s;
      end else begin
        credit_nxt_s = (o_eop && (credit_r != {WBITS{1'b0}})) ?
                       (credit_r - WBITS'(1'b1)) : credit_r;
      end
      case (state_r)
        S_ARB:   state_nxt_s = o_eop ? S_ARB : S_PKT;
        S_PKT:   state_nxt_s = o_eop ? S_ARB : S_PKT;
        default: state_nxt_s = S_ARB;
      endcase
    end else begin
      state_nxt_s  = state_r;
      last_nxt_s   = last_r;
      credit_nxt_s = credit_r;
    end
  end

  // State registers; reset leaves input NI-1 as last so input 0 wins first.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= S_ARB;
      last_r   <= NIBITS'(NI - 1);
      credit_r <= {WBITS{1'b0}};
    end else begin
      state_r  <= state_nxt_s;
      last_r   <= last_nxt_s;
      credit_r <= credit_nxt_s;
    end
  end

endmodule
